pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register for the MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline stage register with valid/ready handshake, an
//                optional 2-entry skid buffer (registered in_ready),
//                synchronous flush and an occupancy count. Strict FIFO order.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] c_ST_EMPTY    = 2'd0;
    localparam logic [1:0] c_ST_FULL     = 2'd1;
    localparam logic [1:0] c_ST_SKIDFULL = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_skid_q;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // State register: reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: flush squashes all held entries, otherwise follow the handshakes.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_fire) w_next_state = c_ST_FULL;
                end
                c_ST_FULL: begin
                    if (w_out_fire && !w_in_fire) begin
                        w_next_state = c_ST_EMPTY;
                    end else if (w_in_fire && !w_out_fire && (SKID != 0)) begin
                        w_next_state = c_ST_SKIDFULL;
                    end
                end
                c_ST_SKIDFULL: begin
                    if (w_out_fire) w_next_state = c_ST_FULL;
                end
                default: w_next_state = c_ST_EMPTY;
            endcase
        end
    end

    // Output/datapath control decoded from the current state and handshakes.
    // Data is never touched during a flush so out_data stays as it was.
    always_comb begin
        out_valid        = (r_state != c_ST_EMPTY);
        occupancy        = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (!flush) begin
            case (r_state)
                c_ST_EMPTY:    w_load_main_in   = w_in_fire;
                c_ST_FULL: begin
                    w_load_main_in = w_in_fire & w_out_fire;
                    w_load_skid    = w_in_fire & ~w_out_fire & (SKID != 0);
                end
                c_ST_SKIDFULL: w_load_main_skid = w_out_fire;
                default: ;
            endcase
        end
    end

    // Main (head) register: captures only on an accepted entry or skid promotion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= RESET_VAL;
        end else if (w_load_main_skid) begin
            r_main <= w_skid_q;
        end else if (w_load_main_in) begin
            r_main <= in_data;
        end
    end

    assign out_data = r_main;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] r_skid;
            logic             r_in_ready;

            // Skid entry: holds the second accepted item while downstream stalls.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_skid <= '0;
                end else if (w_load_skid) begin
                    r_skid <= in_data;
                end
            end

            // Registered ready: low only when the stage will be holding two entries.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_next_state != c_ST_SKIDFULL);
                end
            end

            assign w_skid_q = r_skid;
            // Reset and flush mask ready directly so nothing is accepted in those cycles.
            assign in_ready = r_in_ready & ~reset & ~flush;
        end else begin : g_noskid
            assign w_skid_q = '0;
            assign in_ready = (~out_valid | out_ready) & ~reset & ~flush;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed, table-driven bench for pipe_stage_reg (SKID=1)
//                plus a hand-written sequence for the SKID=0 variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    logic         flush0;
    logic         in_valid0;
    logic         in_ready0;
    logic [W-1:0] in_data0;
    logic         out_valid0;
    logic         out_ready0;
    logic [W-1:0] out_data0;
    logic [1:0]   occupancy0;

    int n_cmp;
    int n_bad;

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL('0), .SKID(1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL('0), .SKID(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush0),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0),
        .occupancy (occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle and the outputs expected just before the next edge.
    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic         e_ir;
        logic [1:0]   e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic fl, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic e_ov, input logic [W-1:0] e_od,
                       input logic e_ir, input logic [1:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ;
        tbl.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'd5; out_ready = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;

        //   rst fl iv data    ordy | ov  od      ir occ
        // reset held, data offered during reset is ignored
        add(1, 0, 1, 32'h5,  0,     0, 32'h0,  0, 0);
        add(0, 0, 0, 32'h0,  1,     0, 32'h0,  1, 0);
        // streaming 1,2,3 without bubbles
        add(0, 0, 1, 32'h1,  1,     0, 32'h0,  1, 0);
        add(0, 0, 1, 32'h2,  1,     1, 32'h1,  1, 1);
        add(0, 0, 1, 32'h3,  1,     1, 32'h2,  1, 1);
        add(0, 0, 0, 32'h0,  1,     1, 32'h3,  1, 1);
        add(0, 0, 0, 32'h0,  0,     0, 32'h3,  1, 0);
        // backpressure fills the skid entry, then drains in order
        add(0, 0, 1, 32'hA,  0,     0, 32'h3,  1, 0);
        add(0, 0, 1, 32'hB,  0,     1, 32'hA,  1, 1);
        add(0, 0, 1, 32'hC,  0,     1, 32'hA,  0, 2);
        add(0, 0, 0, 32'h0,  1,     1, 32'hA,  0, 2);
        add(0, 0, 0, 32'h0,  1,     1, 32'hB,  1, 1);
        add(0, 0, 0, 32'h0,  1,     0, 32'hB,  1, 0);
        // flush while SKIDFULL drops the offered 0x7
        add(0, 0, 1, 32'h1,  0,     0, 32'hB,  1, 0);
        add(0, 0, 1, 32'h2,  0,     1, 32'h1,  1, 1);
        add(0, 1, 1, 32'h7,  0,     1, 32'h1,  0, 2);
        add(0, 0, 0, 32'h0,  0,     0, 32'h1,  1, 0);
        add(0, 0, 0, 32'h0,  1,     0, 32'h1,  1, 0);
        // reset while SKIDFULL, then a lone push of 0x9
        add(0, 0, 1, 32'h4,  0,     0, 32'h1,  1, 0);
        add(0, 0, 1, 32'h6,  0,     1, 32'h4,  1, 1);
        add(1, 0, 0, 32'h0,  0,     1, 32'h4,  0, 2);
        add(0, 0, 1, 32'h9,  0,     0, 32'h0,  1, 0);
        add(0, 0, 0, 32'h0,  1,     1, 32'h9,  1, 1);
        add(0, 0, 0, 32'h0,  1,     0, 32'h9,  1, 0);
        // flush coinciding with an out_fire in FULL
        add(0, 0, 1, 32'h8,  0,     0, 32'h9,  1, 0);
        add(0, 1, 1, 32'h5,  1,     1, 32'h8,  0, 1);
        add(0, 0, 0, 32'h0,  0,     0, 32'h8,  1, 0);

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            chk("out_valid", i, {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
            chk("out_data",  i, out_data, tbl[i].e_od);
            chk("in_ready",  i, {31'b0, in_ready}, {31'b0, tbl[i].e_ir});
            chk("occupancy", i, {30'b0, occupancy}, {30'b0, tbl[i].e_occ});
        end

        // SKID=0 variant: combinational ready and replace-on-fire.
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b1; in_data0 = 32'h11; out_ready0 = 1'b0;
        #1;
        chk("s0_ready_empty", 100, {31'b0, in_ready0}, 32'd1);
        @(negedge clk);
        in_data0 = 32'h22;
        #1;
        chk("s0_valid", 101, {31'b0, out_valid0}, 32'd1);
        chk("s0_data", 101, out_data0, 32'h11);
        chk("s0_ready_stall", 101, {31'b0, in_ready0}, 32'd0);
        @(negedge clk);
        #1;
        chk("s0_hold", 102, out_data0, 32'h11);
        chk("s0_occ_max1", 102, {30'b0, occupancy0}, 32'd1);
        out_ready0 = 1'b1;
        #1;
        chk("s0_ready_same_cycle", 102, {31'b0, in_ready0}, 32'd1);
        @(negedge clk);
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        #1;
        chk("s0_replace", 103, out_data0, 32'h22);
        chk("s0_occ", 103, {30'b0, occupancy0}, 32'd1);
        chk("s0_ready_low", 103, {31'b0, in_ready0}, 32'd0);
        out_ready0 = 1'b1;
        #1;
        chk("s0_ready_high", 103, {31'b0, in_ready0}, 32'd1);
        @(negedge clk);
        out_ready0 = 1'b0;
        #1;
        chk("s0_drained_valid", 104, {31'b0, out_valid0}, 32'd0);
        chk("s0_drained_occ", 104, {30'b0, occupancy0}, 32'd0);
        chk("s0_idle_data", 104, out_data0, 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
